s2p_rr_arbiter: RTL
===================

// Module: s2p_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one serial-to-parallel deserializer (s_to_p) among NUM_SRC serial sources.
//  Grants one source for a whole FRAME_BITS-bit frame and forwards its valid/data/ready handshake.
//  Tags each beat with the source id and marks the last bit of the frame.
//  Sits between the serial requesters and the s_to_p valid_a/data_a/ready_a port.
// PARAMETERS
//  NUM_SRC    4  number of serial requesters (>=2)
//  FRAME_BITS 6  accepted beats per frame; must equal deserializer output width
//  ID_W       2  width of s_id; must satisfy 2**ID_W >= NUM_SRC
// PORTS
//  clk        in   1           rising-edge clock; single clock domain
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NUM_SRC     per-source bit valid
//  req_data   in   NUM_SRC     per-source serial bit
//  req_ready  out  NUM_SRC     per-source ready; only the granted bit can be 1
//  s_valid    out  1           to deserializer valid_a
//  s_data     out  1           to deserializer data_a
//  s_ready    in   1           from deserializer ready_a
//  s_id       out  ID_W        index of granted source
//  s_last     out  1           current beat is bit FRAME_BITS-1 of the frame
//  busy       out  1           a grant is held
// BEHAVIOUR
//  State:
//   - st (IDLE/BUSY), grant[ID_W], ptr[ID_W] (highest-priority index), cnt (0..FRAME_BITS-1).
//  Reset:
//   - rst=1 at an edge gives st=IDLE, grant=0, ptr=0, cnt=0.
//   - All outputs are 0 in IDLE, so every output reads 0 the cycle after reset.
//   - A reset mid-frame discards the partial frame; no beat is replayed.
//  Arbitration:
//   - Search req_valid starting at ptr, ascending, wrapping NUM_SRC-1 -> 0.
//   - The first asserted source wins.
//  IDLE:
//   - If any req_valid: grant<=winner, st<=BUSY, cnt<=0. Otherwise stay in IDLE.
//   - Latency: req_valid seen at edge N gives s_valid at cycle N+1.
//  BUSY (combinational forwarding):
//   - s_valid=req_valid[grant], s_data=req_data[grant], req_ready[grant]=s_ready, other req_ready=0.
//   - s_id=grant, busy=1, s_last=(cnt==FRAME_BITS-1).
//   - Beat = s_valid & s_ready. On a beat: cnt<=cnt+1; no beat leaves cnt unchanged.
//  Gaps and back-pressure:
//   - The granted source may drop valid for any number of cycles; the grant is held (no timeout).
//   - While s_ready=0, no beat is counted; s_data is simply req_data[grant].
//  Frame end (beat with s_last=1):
//   - cnt<=0 and ptr<=(grant+1) mod NUM_SRC.
//   - At that same edge, re-arbitrate from the new ptr using current req_valid, with the
//     finishing source excluded for this one decision.
//   - If a winner exists, stay BUSY with the new grant (no bubble). Otherwise st<=IDLE.
//  Wrap rules:
//   - ptr and grant wrap modulo NUM_SRC; values >=NUM_SRC never occur.
//   - cnt wraps only through the frame-end rule.
//  Simultaneous events:
//   - rst has priority over every other event.
//   - A newly asserted request during BUSY never preempts the current frame.
// TESTING
//  T1 single source:
//   - src1 sends 1,0,1,0,0,0 with s_ready=1.
//   - -> s_id=1 from the cycle after request; 6 beats; s_last only on the 6th; busy falls after it;
//     deserializer gets data_b=6'b101000.
//  T2 all four request from reset:
//   - -> frames granted in order 0,1,2,3 then 0.
//   - -> no idle cycle between frames; req_ready is one-hot on the granted source.
//  T3 gap:
//   - src2 granted; drops valid for 3 cycles after beat 2 while src0 requests.
//   - -> s_id stays 2; cnt stays 2 during the gap; src0 granted only after src2's 6th beat.
//  T4 back-pressure:
//   - s_ready=0 for 4 cycles mid-frame.
//   - -> req_ready[grant]=0 in those cycles; no beat counted; frame completes only after 6 accepted beats.
//  T5 reset mid-frame:
//   - rst=1 after 3 beats of src3.
//   - -> next cycle: s_valid=0, busy=0, s_id=0, req_ready=0.
//   - -> src3 re-request needs a full 6 beats; src0 wins if it requests together with src3.
//  T6 wrap fairness:
//   - src3 and src0 request continuously.
//   - -> grants alternate 0,3,0,3; ptr wraps 3->0.

Source files
------------

// File: rtl/s2p_rr_arbiter.sv
// Round-robin arbiter that lends one serial-to-parallel deserializer to NUM_SRC
// serial sources, holding each grant for one whole FRAME_BITS-beat frame.
module s2p_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int FRAME_BITS = 6,
    parameter int ID_W       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req_valid,
    input  logic [NUM_SRC-1:0] req_data,
    output logic [NUM_SRC-1:0] req_ready,
    output logic               s_valid,
    output logic               s_data,
    input  logic               s_ready,
    output logic [ID_W-1:0]    s_id,
    output logic               s_last,
    output logic               busy
);
    localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             st, st_nxt;
    logic [ID_W-1:0]    grant, grant_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, ptr_after;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    arb_start, arb_win;
    logic [NUM_SRC-1:0] arb_mask;
    logic               arb_found;
    logic               beat;

    assign ptr_after = ID_W'((int'(grant) + 1) % NUM_SRC);

    // At frame end the search starts past the finishing source and skips it,
    // so the re-grant lands on the same edge with no bubble.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        arb_start = (st == BUSY) ? ptr_after : ptr;
        arb_mask  = req_valid;
        if (st == BUSY) begin
            arb_mask[grant] = 1'b0;
        end
        arb_found = 1'b0;
        arb_win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = ID_W'((int'(arb_start) + i) % NUM_SRC);
            if (!arb_found && arb_mask[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
    end

    always_comb begin
        st_nxt    = st;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        s_valid   = 1'b0;
        s_data    = 1'b0;
        s_last    = 1'b0;
        s_id      = '0;
        busy      = 1'b0;
        req_ready = '0;
        beat      = 1'b0;
        case (st)
            IDLE: begin
                if (arb_found) begin
                    st_nxt    = BUSY;
                    grant_nxt = arb_win;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                s_valid          = req_valid[grant];
                s_data           = req_data[grant];
                req_ready[grant] = s_ready;
                s_id             = grant;
                busy             = 1'b1;
                s_last           = (cnt == CNT_W'(FRAME_BITS - 1));
                beat             = s_valid & s_ready;
                if (beat) begin
                    if (s_last) begin
                        cnt_nxt = '0;
                        ptr_nxt = ptr_after;
                        if (arb_found) begin
                            grant_nxt = arb_win;
                        end else begin
                            st_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            st    <= st_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule
